// File: rtl/sn_prot_pkg.sv
// Shared types and constants for the software register protocol handler.
// Holds the FSM state enum, header bit positions and prot bus widths.
package sn_prot_pkg;

    localparam int L_PROT_ADDR_BW = 7;
    localparam int L_PROT_DATA_BW = 8;

    localparam int L_HDR_DIR_BIT  = 7;
    localparam int L_HDR_ADDR_MSB = 6;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        WDATA,
        WEXEC,
        RREQ,
        RSEND
    } t_prot_state;

endpackage

// File: rtl/sn_prot_timeout.sv
// Idle-cycle watchdog for frames in progress.
// Ports: clk, rst, clr (zero the count), en (count this cycle), fire (limit hit).
module sn_prot_timeout #(
    parameter int P_TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic fire
);

    generate
        if (P_TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_tmo;
            assign unused_tmo = ^{clk, rst, clr, en};
            assign fire = 1'b0;
        end else begin : g_on
            localparam int L_W = $clog2(P_TIMEOUT_CYCLES + 1);
            localparam logic [L_W-1:0] L_LAST = L_W'(P_TIMEOUT_CYCLES - 1);

            logic [L_W-1:0] tmo_cnt;

            // Fires on the idle cycle that brings the count to the limit;
            // a byte arriving in that same cycle clears instead.
            assign fire = en && !clr && (tmo_cnt == L_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tmo_cnt <= '0;
                end else if (clr || fire) begin
                    tmo_cnt <= '0;
                end else if (en) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sn_prot_handler.sv
// Host-side initiator turning framed rx bytes into prot_* register accesses.
// Ports: rx/tx byte streams (vld/rdy), prot_* register bus, busy, err_timeout.
module sn_prot_handler
    import sn_prot_pkg::*;
#(
    parameter int P_ADDR_BW        = L_PROT_ADDR_BW,
    parameter int P_DATA_BW        = L_PROT_DATA_BW,
    parameter int P_TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_vld,
    input  logic [P_DATA_BW-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 tx_vld,
    output logic [P_DATA_BW-1:0] tx_data,
    input  logic                 tx_rdy,
    output logic                 prot_enable,
    output logic                 prot_r0w1,
    output logic [P_ADDR_BW-1:0] prot_addr,
    output logic [P_DATA_BW-1:0] prot_wdata,
    input  logic [P_DATA_BW-1:0] prot_rdata,
    output logic                 busy,
    output logic                 err_timeout
);

    t_prot_state state, state_nxt;

    logic                 dir_q;
    logic [P_ADDR_BW-1:0] addr_q;
    logic [7:0]           cnt_q;
    logic [P_DATA_BW-1:0] wdata_q;
    logic [P_DATA_BW-1:0] tx_data_q;

    // Last-issued bus values, so the bus holds while prot_enable is low.
    logic                 hold_r0w1_q;
    logic [P_ADDR_BW-1:0] hold_addr_q;
    logic [P_DATA_BW-1:0] hold_wdata_q;

    logic err_q;
    logic rx_hs;
    logic tmo_en;
    logic tmo_clr;
    logic tmo_fire;
    logic last;

    assign rx_hs   = rx_vld && rx_rdy;
    assign last    = (cnt_q == 8'd0);
    assign tmo_en  = (state == LEN) || (state == WDATA);
    assign tmo_clr = rx_hs || !tmo_en;

    sn_prot_timeout #(
        .P_TIMEOUT_CYCLES(P_TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmo_clr),
        .en   (tmo_en),
        .fire (tmo_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rx_rdy      = 1'b0;
        tx_vld      = 1'b0;
        prot_enable = 1'b0;
        prot_r0w1   = hold_r0w1_q;
        prot_addr   = hold_addr_q;
        prot_wdata  = hold_wdata_q;
        unique case (state)
            IDLE: begin
                rx_rdy = 1'b1;
                if (rx_hs) state_nxt = LEN;
            end
            LEN: begin
                rx_rdy = 1'b1;
                if (rx_hs) state_nxt = dir_q ? WDATA : RREQ;
                else if (tmo_fire) state_nxt = IDLE;
            end
            WDATA: begin
                rx_rdy = 1'b1;
                if (rx_hs) state_nxt = WEXEC;
                else if (tmo_fire) state_nxt = IDLE;
            end
            WEXEC: begin
                prot_enable = 1'b1;
                prot_r0w1   = 1'b1;
                prot_addr   = addr_q;
                prot_wdata  = wdata_q;
                state_nxt   = last ? IDLE : WDATA;
            end
            RREQ: begin
                prot_enable = 1'b1;
                prot_r0w1   = 1'b0;
                prot_addr   = addr_q;
                state_nxt   = RSEND;
            end
            RSEND: begin
                tx_vld = 1'b1;
                if (tx_rdy) state_nxt = last ? IDLE : RREQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q        <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            tx_data_q    <= '0;
            hold_r0w1_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= tmo_fire;
            unique case (state)
                IDLE: begin
                    if (rx_hs) begin
                        dir_q  <= rx_data[L_HDR_DIR_BIT];
                        addr_q <= rx_data[L_HDR_ADDR_MSB:0];
                    end
                end
                LEN: begin
                    if (rx_hs) cnt_q <= rx_data;
                end
                WDATA: begin
                    if (rx_hs) wdata_q <= rx_data;
                end
                WEXEC: begin
                    hold_r0w1_q  <= 1'b1;
                    hold_addr_q  <= addr_q;
                    hold_wdata_q <= wdata_q;
                    if (!last) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                RREQ: begin
                    hold_r0w1_q <= 1'b0;
                    hold_addr_q <= addr_q;
                    tx_data_q   <= prot_rdata;
                end
                RSEND: begin
                    if (tx_rdy && !last) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign busy        = (state != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sn_prot_handler.sv
// Directed testbench for sn_prot_handler.
// Register model returns addr ^ 0x3C; bus and tx events are logged at negedge.
module tb_sn_prot_handler;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_vld;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       tx_vld;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       prot_enable;
    logic       prot_r0w1;
    logic [6:0] prot_addr;
    logic [7:0] prot_wdata;
    logic [7:0] prot_rdata;
    logic       busy;
    logic       err_timeout;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;

    logic [15:0] prot_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    assign prot_rdata = {1'b0, prot_addr} ^ 8'h3C;

    sn_prot_handler #(
        .P_TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_vld      (rx_vld),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .tx_vld      (tx_vld),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .prot_enable (prot_enable),
        .prot_r0w1   (prot_r0w1),
        .prot_addr   (prot_addr),
        .prot_wdata  (prot_wdata),
        .prot_rdata  (prot_rdata),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (prot_enable) prot_q.push_back({prot_r0w1, prot_addr, prot_wdata});
            if (tx_vld && tx_rdy) tx_q.push_back(tx_data);
            if (err_timeout) err_cnt++;
        end
    end

    task automatic clear_logs();
        prot_q.delete();
        tx_q.delete();
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_vld  = 1'b1;
        rx_data = b;
        while (!rx_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!rx_rdy) begin
            failures++;
            $display("FAIL send_byte: rx_rdy=%0b required 1 (byte %h)", rx_rdy, b);
        end
        @(posedge clk); #1;
        rx_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_vld = 1'b0;
        rx_data = 8'h00;
        tx_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_rdy, tx_vld, prot_enable, prot_r0w1, busy, err_timeout} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 100000",
                     {rx_rdy, tx_vld, prot_enable, prot_r0w1, busy, err_timeout});
        end
        checks++;
        if ({tx_data, prot_addr, prot_wdata} !== 23'd0) begin
            failures++;
            $display("FAIL reset_data: tx=%h addr=%h wdata=%h required 0",
                     tx_data, prot_addr, prot_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        clear_logs();
        send_byte(8'h85);
        send_byte(8'h00);
        send_byte(8'hA5);
        checks++;
        if ({prot_enable, prot_r0w1, prot_addr, prot_wdata} !== 17'h1_85A5) begin
            failures++;
            $display("FAIL write_strobe: en=%0b r0w1=%0b addr=%h wdata=%h required 1 1 05 a5",
                     prot_enable, prot_r0w1, prot_addr, prot_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if ({prot_enable, prot_r0w1, prot_addr, prot_wdata, busy} !== 18'h0_85A5 << 1) begin
            failures++;
            $display("FAIL write_hold: en=%0b r0w1=%0b addr=%h wdata=%h busy=%0b required 0 1 05 a5 0",
                     prot_enable, prot_r0w1, prot_addr, prot_wdata, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (prot_q.size() != 1 || prot_q[0] !== 16'h85A5 || tx_q.size() != 0) begin
            failures++;
            $display("FAIL write_log: prot=%0d first=%h tx=%0d required 1 85a5 0",
                     prot_q.size(), (prot_q.size() > 0) ? prot_q[0] : 16'h0, tx_q.size());
        end
    endtask

    task automatic test_burst_read_wrap();
        logic [7:0] exp_addr[3];
        logic [7:0] exp_tx[3];
        int bad;
        exp_addr = '{8'h7E, 8'h7F, 8'h00};
        exp_tx   = '{8'h42, 8'h43, 8'h3C};
        clear_logs();
        tx_rdy = 1'b1;
        send_byte(8'h7E);
        send_byte(8'h02);
        wait_idle();
        checks++;
        if (prot_q.size() != 3 || tx_q.size() != 3) begin
            failures++;
            $display("FAIL burst_count: prot=%0d tx=%0d required 3 3",
                     prot_q.size(), tx_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 3; i++) begin
                if (prot_q[i][15:8] !== exp_addr[i]) bad++;
                if (tx_q[i] !== exp_tx[i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL burst_data: prot %h %h %h tx %h %h %h required 7e 7f 00 / 42 43 3c",
                         prot_q[0][15:8], prot_q[1][15:8], prot_q[2][15:8],
                         tx_q[0], tx_q[1], tx_q[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        clear_logs();
        tx_rdy = 1'b0;
        send_byte(8'h10);
        send_byte(8'h00);
        n = 0;
        while (!tx_vld && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (tx_vld !== 1'b1 || tx_data !== 8'h2C) begin
            failures++;
            $display("FAIL bp_first: vld=%0b data=%h required 1 2c", tx_vld, tx_data);
        end
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_vld !== 1'b1 || tx_data !== 8'h2C || prot_enable !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || prot_q.size() != 1) begin
            failures++;
            $display("FAIL bp_hold: unstable cycles=%0d prot=%0d required 0 1",
                     bad, prot_q.size());
        end
        tx_rdy = 1'b1;
        wait_idle();
        checks++;
        if (tx_q.size() != 1 || prot_q.size() != 1 || (tx_q.size() > 0 && tx_q[0] !== 8'h2C)) begin
            failures++;
            $display("FAIL bp_release: tx=%0d prot=%0d required 1 1 (byte 2c)",
                     tx_q.size(), prot_q.size());
        end
    endtask

    task automatic test_timeout();
        int bad;
        clear_logs();
        send_byte(8'h81);
        bad = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (busy !== 1'b1 || err_timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL tmo_early: bad cycles=%0d required 0", bad);
        end
        @(posedge clk); #1;
        checks++;
        if ({err_timeout, busy} !== 2'b10) begin
            failures++;
            $display("FAIL tmo_fire: err=%0b busy=%0b required 1 0", err_timeout, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (err_timeout !== 1'b0 || err_cnt != 1 || prot_q.size() != 0) begin
            failures++;
            $display("FAIL tmo_pulse: err=%0b pulses=%0d prot=%0d required 0 1 0",
                     err_timeout, err_cnt, prot_q.size());
        end
        clear_logs();
        send_byte(8'h81);
        send_byte(8'h00);
        send_byte(8'h5A);
        wait_idle();
        checks++;
        if (prot_q.size() != 1 || prot_q[0] !== 16'h815A) begin
            failures++;
            $display("FAIL tmo_recover: prot=%0d first=%h required 1 815a",
                     prot_q.size(), (prot_q.size() > 0) ? prot_q[0] : 16'h0);
        end
    endtask

    task automatic test_race();
        clear_logs();
        send_byte(8'h81);
        repeat (15) @(posedge clk);
        #1;
        rx_vld  = 1'b1;
        rx_data = 8'h00;
        @(posedge clk); #1;
        rx_vld = 1'b0;
        checks++;
        if ({busy, err_timeout} !== 2'b10 || rx_rdy !== 1'b1) begin
            failures++;
            $display("FAIL race_accept: busy=%0b err=%0b rdy=%0b required 1 0 1",
                     busy, err_timeout, rx_rdy);
        end
        send_byte(8'h77);
        wait_idle();
        checks++;
        if (err_cnt != 0 || prot_q.size() != 1 || prot_q[0] !== 16'h8177) begin
            failures++;
            $display("FAIL race_write: pulses=%0d prot=%0d first=%h required 0 1 8177",
                     err_cnt, prot_q.size(), (prot_q.size() > 0) ? prot_q[0] : 16'h0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        clear_logs();
        tx_rdy = 1'b0;
        send_byte(8'h20);
        send_byte(8'h03);
        n = 0;
        while (!tx_vld && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tx_rdy = 1'b1;
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (tx_vld !== 1'b1 || tx_data !== 8'h1D || tx_q.size() != 1) begin
            failures++;
            $display("FAIL rst_pre: vld=%0b data=%h sent=%0d required 1 1d 1",
                     tx_vld, tx_data, tx_q.size());
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_rdy, tx_vld, prot_enable, prot_r0w1, busy, err_timeout} !== 6'b100000 ||
            {tx_data, prot_addr, prot_wdata} !== 23'd0) begin
            failures++;
            $display("FAIL rst_async: ctrl=%b tx=%h addr=%h wdata=%h required 100000 0 0 0",
                     {rx_rdy, tx_vld, prot_enable, prot_r0w1, busy, err_timeout},
                     tx_data, prot_addr, prot_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        tx_rdy = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        send_byte(8'hB3);
        send_byte(8'h00);
        send_byte(8'h99);
        wait_idle();
        checks++;
        if (prot_q.size() != 1 || prot_q[0] !== 16'hB399 || tx_q.size() != 0) begin
            failures++;
            $display("FAIL rst_recover: prot=%0d first=%h tx=%0d required 1 b399 0",
                     prot_q.size(), (prot_q.size() > 0) ? prot_q[0] : 16'h0, tx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_read_wrap();
        test_backpressure();
        test_timeout();
        test_race();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
